// File: rtl/proc_bus_ctrl.sv
// Memory/IO bus controller between the processor and on-chip RAM, LEDs, display and switches.
// Registers read data every edge and stalls the processor's run for WAIT_STATES cycles per address change.
module proc_bus_ctrl #(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic        run_in,
    output logic        run_out,
    input  logic [15:0] proc_addr,
    input  logic [15:0] proc_dout,
    input  logic        proc_wr,
    output logic [15:0] proc_din,
    input  logic [8:0]  SW,
    output logic [8:0]  LEDR,
    output logic [15:0] seg_value,
    output logic        bus_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] WS  = CW'(WAIT_STATES);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [15:0]     addr_q;
    logic            change;
    logic [3:0]      region;
    logic [AW-1:0]   idx;
    logic            bus_wr;
    logic [15:0]     rd_value;
    logic [8:0]      sw_meta;
    logic [8:0]      sw_sync;
    logic [15:0]     mem [DEPTH];

    assign region  = proc_addr[15:12];
    assign idx     = proc_addr[AW-1:0];
    assign change  = (proc_addr != addr_q);
    // Processor address is registered upstream, so this combinational path forms no loop.
    assign run_out = run_in & (state == ST_IDLE) & ~change & reset;
    assign bus_wr  = run_out & proc_wr;

    // Stall FSM next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_FILL: begin
                if (cnt <= ONE) state_nxt = ST_IDLE;
                else            cnt_nxt   = cnt - ONE;
            end
            ST_IDLE: begin
                if (change && (WAIT_STATES > 1)) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = WS - ONE;
                end
            end
            ST_WAIT: begin
                if (change)           cnt_nxt   = WS - ONE;
                else if (cnt <= ONE)  state_nxt = ST_IDLE;
                else                  cnt_nxt   = cnt - ONE;
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    // Read decode; RAM read sees pre-write contents on a same-edge write
    always_comb begin
        rd_value = '0;
        case (region)
            4'h0:    rd_value = mem[idx];
            4'h1:    rd_value = {7'b0, LEDR};
            4'h2:    rd_value = seg_value;
            4'h3:    rd_value = {7'b0, sw_sync};
            default: rd_value = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_FILL;
            cnt       <= WS;
            addr_q    <= '0;
            proc_din  <= '0;
            LEDR      <= '0;
            seg_value <= '0;
            bus_err   <= 1'b0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            addr_q   <= proc_addr;
            proc_din <= rd_value;
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            if (bus_wr && (region == 4'h1)) LEDR      <= proc_dout[8:0];
            if (bus_wr && (region == 4'h2)) seg_value <= proc_dout;
            if (run_out && ((region >= 4'h4) || ((region == 4'h3) && proc_wr)))
                bus_err <= 1'b1;
        end
    end

    // Word RAM, contents not reset
    always_ff @(posedge Clock) begin
        if (bus_wr && (region == 4'h0)) mem[idx] <= proc_dout;
    end

endmodule

// File: tb/tb_proc_bus_ctrl.sv
// Directed bench for proc_bus_ctrl: one instance with WAIT_STATES=1, one with WAIT_STATES=3,
// sharing all inputs so each can be checked against hand-computed cycle timing.
module tb_proc_bus_ctrl;

    logic        Clock = 1'b0;
    logic        reset;
    logic        run_in;
    logic [15:0] proc_addr;
    logic [15:0] proc_dout;
    logic        proc_wr;
    logic [8:0]  SW;

    logic        run1, run3;
    logic [15:0] din1, din3;
    logic [8:0]  led1, led3;
    logic [15:0] seg1, seg3;
    logic        err1, err3;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    proc_bus_ctrl #(.DEPTH(128), .WAIT_STATES(1)) dut1 (
        .Clock(Clock), .reset(reset), .run_in(run_in), .run_out(run1),
        .proc_addr(proc_addr), .proc_dout(proc_dout), .proc_wr(proc_wr),
        .proc_din(din1), .SW(SW), .LEDR(led1), .seg_value(seg1), .bus_err(err1)
    );

    proc_bus_ctrl #(.DEPTH(128), .WAIT_STATES(3)) dut3 (
        .Clock(Clock), .reset(reset), .run_in(run_in), .run_out(run3),
        .proc_addr(proc_addr), .proc_dout(proc_dout), .proc_wr(proc_wr),
        .proc_din(din3), .SW(SW), .LEDR(led3), .seg_value(seg3), .bus_err(err3)
    );

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; run_in = 1'b1; proc_addr = 16'h0000;
        proc_dout = 16'h0000; proc_wr = 1'b0; SW = 9'h000;
        tick(); tick();

        // Reset values
        chk1 ("rst_run1", run1, 1'b0);
        chk16("rst_din1", din1, 16'h0000);
        chk16("rst_led1", 16'(led1), 16'h0000);
        chk16("rst_seg1", seg1, 16'h0000);
        chk1 ("rst_err1", err1, 1'b0);
        chk1 ("rst_run3", run3, 1'b0);

        // Reset release: fill lasts WAIT_STATES cycles
        reset = 1'b1; #1;
        chk1("fill_run1_c0", run1, 1'b0);
        chk1("fill_run3_c0", run3, 1'b0);
        tick();
        chk1("fill_run1_c1", run1, 1'b1);
        chk1("fill_run3_c1", run3, 1'b0);
        tick();
        chk1("fill_run3_c2", run3, 1'b0);
        tick();
        chk1("fill_run3_c3", run3, 1'b1);

        // RAM write 0xBEEF to 0x0005
        proc_addr = 16'h0005; proc_dout = 16'hBEEF; proc_wr = 1'b1; #1;
        chk1("w5_stall1", run1, 1'b0);
        tick();
        chk1("w5_run1", run1, 1'b1);
        chk1("w5_stall3_c1", run3, 1'b0);
        tick();
        chk1("w5_stall3_c2", run3, 1'b0);
        tick();
        chk16("w5_din1", din1, 16'hBEEF);
        chk1 ("w5_run3_c3", run3, 1'b1);
        tick();
        proc_wr = 1'b0;

        // Move to 0x0006 and back to 0x0005
        proc_addr = 16'h0006; #1;
        chk1("a6_stall1", run1, 1'b0);
        tick();
        chk1("a6_run1", run1, 1'b1);
        proc_addr = 16'h0005; #1;
        chk1("a5_stall1", run1, 1'b0);
        tick();
        chk16("a5_din1", din1, 16'hBEEF);
        chk1 ("a5_run1", run1, 1'b1);

        // Read-before-write on 0x0006
        proc_addr = 16'h0006; proc_dout = 16'h1111; proc_wr = 1'b1; #1;
        tick();
        tick();
        proc_dout = 16'h2222;
        tick();
        chk16("rbw_old", din1, 16'h1111);
        tick();
        chk16("rbw_new", din1, 16'h2222);
        proc_wr = 1'b0;

        // WAIT_STATES=3: write 0xCAFE to 0x0010
        proc_addr = 16'h0010; proc_dout = 16'hCAFE; proc_wr = 1'b1; #1;
        chk1("w10_run3_c0", run3, 1'b0);
        tick();
        chk1("w10_run3_c1", run3, 1'b0);
        tick();
        chk1("w10_run3_c2", run3, 1'b0);
        tick();
        chk1("w10_run3_c3", run3, 1'b1);
        tick();
        proc_wr = 1'b0;

        // 0x0000 -> 0x0010: exactly 3 stall cycles, data valid before run rises
        proc_addr = 16'h0000;
        tick(); tick(); tick();
        proc_addr = 16'h0010; #1;
        chk1("r10_run3_c0", run3, 1'b0);
        tick();
        chk1 ("r10_run3_c1", run3, 1'b0);
        chk16("r10_din3", din3, 16'hCAFE);
        tick();
        chk1("r10_run3_c2", run3, 1'b0);
        tick();
        chk1("r10_run3_c3", run3, 1'b1);

        // LEDR write and readback
        proc_addr = 16'h1000; proc_dout = 16'h01AA; proc_wr = 1'b1; #1;
        tick(); tick();
        chk16("led_val", 16'(led1), 16'h01AA);
        proc_wr = 1'b0;
        tick();
        chk16("led_rd", din1, 16'h01AA);

        // seg_value write and readback
        proc_addr = 16'h2000; proc_dout = 16'h1234; proc_wr = 1'b1; #1;
        tick(); tick();
        chk16("seg_val", seg1, 16'h1234);
        proc_wr = 1'b0;
        tick();
        chk16("seg_rd", din1, 16'h1234);

        // Switches through the synchronizer, then illegal write
        SW = 9'h155; proc_addr = 16'h3000;
        tick(); tick();
        chk16("sw_e2", din1, 16'h0000);
        tick();
        chk16("sw_e3", din1, 16'h0155);
        chk1 ("sw_noerr", err1, 1'b0);
        proc_wr = 1'b1; proc_dout = 16'hFFFF; #1;
        chk1("swwr_run1", run1, 1'b1);
        tick();
        chk1("swwr_err1", err1, 1'b1);
        proc_wr = 1'b0;
        tick();
        chk16("swwr_din1", din1, 16'h0155);

        // Reset clears bus_err asynchronously
        reset = 1'b0; #1;
        chk1("rst2_err1", err1, 1'b0);
        chk1("rst2_run1", run1, 1'b0);
        tick();
        reset = 1'b1;
        tick(); tick(); tick();

        // run_in low: no writes
        run_in = 1'b0; proc_addr = 16'h1000; proc_dout = 16'h0055; proc_wr = 1'b1;
        tick(); tick(); tick(); tick();
        chk1 ("norun_run1", run1, 1'b0);
        chk16("norun_led1", 16'(led1), 16'h0000);
        chk16("norun_led3", 16'(led3), 16'h0000);
        proc_wr = 1'b0; run_in = 1'b1;

        // Unmapped read sets sticky bus_err
        proc_addr = 16'h8000; #1;
        tick(); tick();
        chk1 ("unm_err1", err1, 1'b1);
        chk16("unm_din1", din1, 16'h0000);
        tick(); tick(); tick();
        chk1("unm_err3", err3, 1'b1);
        proc_addr = 16'h0005;
        tick();
        chk1("unm_sticky1", err1, 1'b1);

        // Reset asserted while dut3 is in WAIT
        reset = 1'b0; #1;
        chk1 ("rstw_err3", err3, 1'b0);
        chk1 ("rstw_run3", run3, 1'b0);
        chk16("rstw_din3", din3, 16'h0000);
        chk1 ("rstw_err1", err1, 1'b0);
        chk16("rstw_seg1", seg1, 16'h0000);
        chk16("rstw_led1", 16'(led1), 16'h0000);
        tick();
        reset = 1'b1;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
